// File: rtl/apb_master.sv
// APB master: bridges a simple CPU req/ready handshake onto a 4-slave APB bus.
// Optional macro APB_TIMEOUT_EN adds an ACCESS-phase timeout that aborts with err.
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic [31:0] paddr_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  psel_o,
    output logic        penable_o,
    input  logic [31:0] prdata0_i,
    input  logic [31:0] prdata1_i,
    input  logic [31:0] prdata2_i,
    input  logic [31:0] prdata3_i,
    input  logic        pready0_i,
    input  logic        pready1_i,
    input  logic        pready2_i,
    input  logic        pready3_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_invalid
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  sel_q;
    logic [31:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [3:0]  psel_q;
    logic        penable_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;

    // Slaves live at 0x1000_0000 + n*0x1000, n = 0..3.
    logic        dec_hit;
    logic [1:0]  dec_idx;
    assign dec_hit = (addr_i[31:14] == 18'h04000);
    assign dec_idx = addr_i[13:12];

    logic        pready_sel;
    logic [31:0] prdata_sel;
    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = 32'h0;
        case (sel_q)
            2'd0: begin pready_sel = pready0_i; prdata_sel = prdata0_i; end
            2'd1: begin pready_sel = pready1_i; prdata_sel = prdata1_i; end
            2'd2: begin pready_sel = pready2_i; prdata_sel = prdata2_i; end
            default: begin pready_sel = pready3_i; prdata_sel = prdata3_i; end
        endcase
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            paddr_q   <= 32'h0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 32'h0;
            psel_q    <= 4'b0000;
            penable_q <= 1'b0;
            rdata_q   <= 32'h0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    psel_q    <= 4'b0000;
                    penable_q <= 1'b0;
                    // ready_q gating gives the mandatory turnaround cycle.
                    if (req_i && !ready_q) begin
                        paddr_q  <= addr_i;
                        pwrite_q <= write_i;
                        pwdata_q <= wdata_i;
                        sel_q    <= dec_idx;
                        if (dec_hit) begin
                            state_q <= SETUP;
                            psel_q  <= 4'b0001 << dec_idx;
`ifdef APB_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end else begin
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        if (!pwrite_q) begin
                            rdata_q <= prdata_sel;
                        end
                        ready_q   <= 1'b1;
                        psel_q    <= 4'b0000;
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= 32'h0;
                        psel_q    <= 4'b0000;
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 4'b0000;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign rdata_o   = rdata_q;
    assign ready_o   = ready_q;
    assign err_o     = err_q;
    assign paddr_o   = paddr_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized transfers
// checked cycle by cycle against a transaction-level expectation model.
module tb_apb_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic [31:0] paddr, pwdata;
    logic        pwrite, penable;
    logic [3:0]  psel;
    logic [31:0] prdata [4];
    logic        pready [4];

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_i(req), .write_i(write), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .ready_o(ready), .err_o(err),
        .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata),
        .psel_o(psel), .penable_o(penable),
        .prdata0_i(prdata[0]), .prdata1_i(prdata[1]),
        .prdata2_i(prdata[2]), .prdata3_i(prdata[3]),
        .pready0_i(pready[0]), .pready1_i(pready[1]),
        .pready2_i(pready[2]), .pready3_i(pready[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Selected slave gets the given pready/prdata; the others are random noise.
    task automatic drive_slaves(input int sel, input logic pr, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            pready[i] = (i == sel) ? pr : 1'($urandom);
            prdata[i] = (i == sel) ? d  : $urandom;
        end
    endtask

    task automatic scribble();
        req   = 1'($urandom);
        write = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    function automatic logic [31:0] valid_addr(input int slave);
        return {20'h10000 + 20'(slave), 12'($urandom)};
    endfunction

    function automatic logic [31:0] bad_addr();
        logic [31:0] a;
        a = $urandom;
        if (a[31:14] == 18'h04000) a[31] = 1'b1;
        return a;
    endfunction

    // One complete transfer from an idle, ready=0 starting cycle. slave<0 means decode error.
    task automatic txn(input int slave, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int nwait, input logic [31:0] rd);
        logic [3:0] ep;
        req = 1'b1; write = wr; addr = a; wdata = wd;
        drive_slaves(slave, 1'($urandom), $urandom);
        step();
        if (slave < 0) begin
            check("decerr_psel", 32'(psel), 32'h0);
            check("decerr_penable", 32'(penable), 32'h0);
            check("decerr_ready", 32'(ready), 32'h1);
            check("decerr_err", 32'(err), 32'h1);
            check("decerr_rdata", rdata, 32'h0);
            model_rdata = 32'h0;
            scribble(); req = 1'b0;
            step();
            check("decerr_ready_drop", 32'(ready), 32'h0);
            check("decerr_idle_psel", 32'(psel), 32'h0);
            return;
        end
        ep = 4'b0001 << slave;
        check("setup_psel", 32'(psel), 32'(ep));
        check("setup_penable", 32'(penable), 32'h0);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", 32'(pwrite), 32'(wr));
        check("setup_pwdata", pwdata, wd);
        scribble();
        drive_slaves(slave, 1'($urandom), $urandom);
        step();
        for (int k = 0; k <= nwait; k++) begin
            check("access_psel", 32'(psel), 32'(ep));
            check("access_penable", 32'(penable), 32'h1);
            check("access_ready", 32'(ready), 32'h0);
            check("access_paddr", paddr, a);
            check("access_pwrite", 32'(pwrite), 32'(wr));
            check("access_pwdata", pwdata, wd);
            scribble();
            drive_slaves(slave, (k == nwait), rd);
            step();
        end
        if (!wr) model_rdata = rd;
        check("done_ready", 32'(ready), 32'h1);
        check("done_err", 32'(err), 32'h0);
        check("done_rdata", rdata, model_rdata);
        check("done_psel", 32'(psel), 32'h0);
        check("done_penable", 32'(penable), 32'h0);
        req = 1'b0;
        drive_slaves(-1, 1'b0, 32'h0);
        step();
        check("post_ready", 32'(ready), 32'h0);
        check("post_psel", 32'(psel), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1; req = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0;
        drive_slaves(-1, 1'b0, 32'h0);
        model_rdata = 32'h0;
        step(); step();
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pwrite", 32'(pwrite), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        step();

        // Load from slave 0, zero wait states.
        txn(0, 1'b0, 32'h1000_0004, 32'h0, 0, 32'hDEAD_BEEF);
        // Store to slave 2 with three wait states; rdata must hold.
        txn(2, 1'b1, 32'h1000_2010, 32'h1234_5678, 3, 32'hFFFF_0000);
        // Decode error.
        txn(-1, 1'b0, 32'h2000_0000, 32'h0, 0, 32'h0);

        // req held high across ready: one idle turnaround, then a new SETUP.
        a = 32'h1000_1008;
        req = 1'b1; write = 1'b0; addr = a; wdata = 32'h0;
        drive_slaves(1, 1'b0, 32'h0);
        step();
        check("b2b_setup1", 32'(psel), 32'h2);
        drive_slaves(1, 1'b1, 32'hCAFE_0001);
        step();
        check("b2b_access1", 32'(penable), 32'h1);
        step();
        check("b2b_ready1", 32'(ready), 32'h1);
        check("b2b_rdata1", rdata, 32'hCAFE_0001);
        step();
        check("b2b_turnaround_psel", 32'(psel), 32'h0);
        check("b2b_turnaround_ready", 32'(ready), 32'h0);
        step();
        check("b2b_setup2_psel", 32'(psel), 32'h2);
        check("b2b_setup2_penable", 32'(penable), 32'h0);
        req = 1'b0;
        drive_slaves(1, 1'b1, 32'hCAFE_0002);
        step();
        check("b2b_access2", 32'(penable), 32'h1);
        step();
        check("b2b_ready2", 32'(ready), 32'h1);
        check("b2b_rdata2", rdata, 32'hCAFE_0002);
        model_rdata = 32'hCAFE_0002;
        step();

        // Reset during ACCESS aborts immediately, no ready afterwards.
        req = 1'b1; write = 1'b0; addr = 32'h1000_3000;
        drive_slaves(3, 1'b0, 32'h0);
        step();
        req = 1'b0;
        step();
        check("rstacc_penable_before", 32'(penable), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rstacc_psel", 32'(psel), 32'h0);
        check("rstacc_penable", 32'(penable), 32'h0);
        step();
        reset = 1'b0;
        drive_slaves(3, 1'b1, 32'h5555_AAAA);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rstacc_no_ready", 32'(ready), 32'h0);
        end
        check("rstacc_rdata", rdata, 32'h0);
        model_rdata = 32'h0;

        // Slave 1 never answers.
        req = 1'b1; write = 1'b0; addr = 32'h1000_1000;
        drive_slaves(1, 1'b0, 32'h0);
        step();
        req = 1'b0;
        step();
`ifdef APB_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            check("to_access_penable", 32'(penable), 32'h1);
            check("to_access_ready", 32'(ready), 32'h0);
            step();
        end
        check("to_ready", 32'(ready), 32'h1);
        check("to_err", 32'(err), 32'h1);
        check("to_rdata", rdata, 32'h0);
        check("to_psel", 32'(psel), 32'h0);
        check("to_penable", 32'(penable), 32'h0);
        step();
`else
        for (int k = 0; k < 100; k++) begin
            if (ready !== 1'b0) check("hang_no_ready", 32'(ready), 32'h0);
            step();
        end
        check("hang_psel", 32'(psel), 32'h2);
        check("hang_penable", 32'(penable), 32'h1);
        check("hang_ready", 32'(ready), 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            int s;
            s = int'($urandom_range(0, 4));
            if (s == 4) begin
                txn(-1, 1'($urandom), bad_addr(), $urandom, 0, 32'h0);
            end else begin
                txn(s, 1'($urandom), valid_addr(s), $urandom,
                    int'($urandom_range(0, 6)), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
